// File: rtl/mips_pipe_pkg.sv
// Shared types and constants for the MIPS32 pipeline hazard controller.
package mips_pipe_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] ZERO_REG = 5'd0;

  // Data-memory sequencer states.
  typedef enum logic [1:0] {
    HZ_IDLE  = 2'd0,
    HZ_WAIT  = 2'd1,
    HZ_ERROR = 2'd2
  } hz_state_t;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle of the hazard controller.
// Handshake: dmem_req rises with the first cycle of a data-memory access and
// stays high until the cycle in which dmem_ready is seen; the access completes
// in the cycle where dmem_req and dmem_ready are both high.
interface pipe_hazard_ctrl_if;
  import mips_pipe_pkg::*;

  logic [REG_W-1:0] ID_Rs;
  logic [REG_W-1:0] ID_Rt;
  logic             ID_UsesRt;
  logic             ID_BranchTaken;
  logic             EX_MemRead;
  logic [REG_W-1:0] EX_Rt;
  logic             MEM_MemRead;
  logic             MEM_MemWrite;
  logic             dmem_ready;
  logic             dmem_req;
  logic             PC_Stall;
  logic             IFID_Stall;
  logic             IFID_Flush;
  logic             IDEX_Stall;
  logic             IDEX_Flush;
  logic             EXMEM_Stall;
  logic             MEMWB_Bubble;
  logic             mem_timeout;

  // Pipeline / memory side: supplies stage fields and ready, consumes controls.
  modport master (
    output ID_Rs, ID_Rt, ID_UsesRt, ID_BranchTaken, EX_MemRead, EX_Rt,
           MEM_MemRead, MEM_MemWrite, dmem_ready,
    input  dmem_req, PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
           EXMEM_Stall, MEMWB_Bubble, mem_timeout
  );

  // Hazard controller side.
  modport slave (
    input  ID_Rs, ID_Rt, ID_UsesRt, ID_BranchTaken, EX_MemRead, EX_Rt,
           MEM_MemRead, MEM_MemWrite, dmem_ready,
    output dmem_req, PC_Stall, IFID_Stall, IFID_Flush, IDEX_Stall, IDEX_Flush,
           EXMEM_Stall, MEMWB_Bubble, mem_timeout
  );

endinterface

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the
// instruction in ID. Register $0 never creates a dependency.
module load_use_detect
  import mips_pipe_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             lu
);

  // Hazard equation; rt only matters when the ID instruction reads it.
  always_comb begin
    lu = ex_mem_read && (ex_rt != ZERO_REG) &&
         ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
// Priority of controls: memory stall > load-use bubble > branch squash.
// Optional macro PIPE_HAZARD_PERF_EN adds memstall / load-use event counters.
// MEM_TIMEOUT must be >= 2.
module pipe_hazard_ctrl
  import mips_pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               reset,
  pipe_hazard_ctrl_if.slave  bus,
  output hz_state_t          state
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [31:0]        perf_memstall_cnt,
  output logic [31:0]        perf_lu_cnt
`endif
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  hz_state_t        state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             mem_acc;
  logic             lu;
  logic             req;
  logic             memstall;

  assign mem_acc = bus.MEM_MemRead | bus.MEM_MemWrite;

  load_use_detect u_lu (
    .ex_mem_read (bus.EX_MemRead),
    .ex_rt       (bus.EX_Rt),
    .id_rs       (bus.ID_Rs),
    .id_rt       (bus.ID_Rt),
    .id_uses_rt  (bus.ID_UsesRt),
    .lu          (lu)
  );

  // Memory sequencer: cnt counts not-ready cycles of the current access;
  // the first miss happens in IDLE, so WAIT sees cnt values 1..MEM_TIMEOUT.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= HZ_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        HZ_IDLE: begin
          if (mem_acc && !bus.dmem_ready) begin
            state_q <= HZ_WAIT;
            cnt_q   <= CNT_W'(1);
          end
        end
        HZ_WAIT: begin
          if (bus.dmem_ready) begin
            state_q <= HZ_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= HZ_ERROR;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        HZ_ERROR: state_q <= HZ_ERROR;
        default: begin
          state_q <= HZ_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  // Request and memory-stall decode from the current state.
  always_comb begin
    req      = 1'b0;
    memstall = 1'b0;
    case (state_q)
      HZ_IDLE: begin
        req      = mem_acc;
        memstall = mem_acc && !bus.dmem_ready;
      end
      HZ_WAIT: begin
        req      = 1'b1;
        memstall = !bus.dmem_ready;
      end
      HZ_ERROR: begin
        req      = 1'b0;
        memstall = 1'b1;
      end
      default: ;
    endcase
  end

  // Pipeline controls with priority applied; everything is quiet during reset.
  always_comb begin
    bus.dmem_req     = 1'b0;
    bus.PC_Stall     = 1'b0;
    bus.IFID_Stall   = 1'b0;
    bus.IFID_Flush   = 1'b0;
    bus.IDEX_Stall   = 1'b0;
    bus.IDEX_Flush   = 1'b0;
    bus.EXMEM_Stall  = 1'b0;
    bus.MEMWB_Bubble = 1'b0;
    bus.mem_timeout  = 1'b0;
    state            = HZ_IDLE;
    if (!reset) begin
      bus.dmem_req     = req;
      bus.PC_Stall     = memstall | lu;
      bus.IFID_Stall   = memstall | lu;
      bus.IFID_Flush   = bus.ID_BranchTaken & ~lu & ~memstall;
      bus.IDEX_Stall   = memstall;
      bus.IDEX_Flush   = lu & ~memstall;
      bus.EXMEM_Stall  = memstall;
      bus.MEMWB_Bubble = memstall;
      bus.mem_timeout  = (state_q == HZ_ERROR);
      state            = state_q;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  // Event counters: memory-stall cycles and inserted load-use bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_memstall_cnt <= '0;
      perf_lu_cnt       <= '0;
    end else begin
      if (memstall)
        perf_memstall_cnt <= perf_memstall_cnt + 32'd1;
      if (lu && !memstall)
        perf_lu_cnt <= perf_lu_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl with a behavioural reference model.
module tb_pipe_hazard_ctrl;
  import mips_pipe_pkg::*;

  localparam int T = 4;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ut;
    logic       br;
    logic       exr;
    logic [4:0] ext;
    logic       mr;
    logic       mw;
    logic       rdy;
  } stim_t;

  // ---------------- clock / reset ----------------
  logic      clk = 1'b0;
  logic      reset = 1'b1;
  hz_state_t state;

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if bus ();

  pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (state)
  );

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: an access is outstanding (busy) until ready is seen;
  // misses counts not-ready cycles of the access; more than T misses is fatal.
  logic m_busy = 1'b0;
  logic m_err  = 1'b0;
  int   m_misses = 0;

  function automatic logic [8:0] model_out();
    logic acc, lu, ms, req;
    if (reset) return 9'd0;
    acc = bus.MEM_MemRead | bus.MEM_MemWrite;
    lu  = bus.EX_MemRead && (bus.EX_Rt != 5'd0) &&
          ((bus.EX_Rt == bus.ID_Rs) || (bus.ID_UsesRt && (bus.EX_Rt == bus.ID_Rt)));
    if (m_err) begin
      req = 1'b0; ms = 1'b1;
    end else if (m_busy) begin
      req = 1'b1; ms = !bus.dmem_ready;
    end else begin
      req = acc;  ms = acc && !bus.dmem_ready;
    end
    return {req, ms | lu, ms | lu, bus.ID_BranchTaken & ~lu & ~ms,
            ms, lu & ~ms, ms, ms, m_err};
  endfunction

  function automatic hz_state_t exp_state();
    if (reset) return HZ_IDLE;
    if (m_err) return HZ_ERROR;
    if (m_busy) return HZ_WAIT;
    return HZ_IDLE;
  endfunction

  function automatic logic [8:0] obs_vec();
    return {bus.dmem_req, bus.PC_Stall, bus.IFID_Stall, bus.IFID_Flush,
            bus.IDEX_Stall, bus.IDEX_Flush, bus.EXMEM_Stall, bus.MEMWB_Bubble,
            bus.mem_timeout};
  endfunction

  task automatic model_step();
    logic acc;
    acc = bus.MEM_MemRead | bus.MEM_MemWrite;
    if (reset) begin
      m_busy = 1'b0; m_err = 1'b0; m_misses = 0;
    end else if (!m_err && (m_busy || acc)) begin
      if (bus.dmem_ready) begin
        m_busy = 1'b0; m_misses = 0;
      end else begin
        m_misses++;
        if (m_misses > T) begin
          m_err = 1'b1; m_busy = 1'b0;
        end else begin
          m_busy = 1'b1;
        end
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input stim_t s);
    @(negedge clk);
    reset              = s.rst;
    bus.ID_Rs          = s.rs;
    bus.ID_Rt          = s.rt;
    bus.ID_UsesRt      = s.ut;
    bus.ID_BranchTaken = s.br;
    bus.EX_MemRead     = s.exr;
    bus.EX_Rt          = s.ext;
    bus.MEM_MemRead    = s.mr;
    bus.MEM_MemWrite   = s.mw;
    bus.dmem_ready     = s.rdy;
    #1;
    exp_q.push_back(model_out());
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t tbl[4];
    logic [8:0] exp;
    tbl[0] = '{1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 5'd8, 5'd8, 1'b1, 1'b1, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      exp = exp_q.pop_front();
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL reset step %0d outputs got %b want %b", i, obs_vec(), exp);
      end
      advance();
      checks++;
      if (state !== exp_state()) begin
        errors++;
        $display("FAIL reset step %0d state got %0d want %0d", i, state, exp_state());
      end
    end
  endtask

  task automatic test_load_use();
    stim_t tbl[7];
    logic [8:0] exp;
    tbl[0] = '{1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd8, 5'd3, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'd0, 5'd3, 1'b0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd3, 5'd8, 1'b0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'd3, 5'd8, 1'b1, 1'b1, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 5'd3, 5'd8, 1'b1, 1'b1, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 7; i++) begin
      drive(tbl[i]);
      exp = exp_q.pop_front();
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL load_use step %0d got %b want %b", i, obs_vec(), exp);
      end
      advance();
    end
  endtask

  task automatic test_mem_wait();
    stim_t tbl[6];
    logic [8:0] exp;
    tbl[0] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      drive(tbl[i]);
      exp = exp_q.pop_front();
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL mem_wait step %0d got %b want %b", i, obs_vec(), exp);
      end
      advance();
      checks++;
      if (state !== exp_state()) begin
        errors++;
        $display("FAIL mem_wait step %0d state got %0d want %0d", i, state, exp_state());
      end
    end
  endtask

  task automatic test_coincidence();
    stim_t tbl[4];
    logic [8:0] exp;
    tbl[0] = '{1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 5'd9, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      drive(tbl[i]);
      exp = exp_q.pop_front();
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL coincidence step %0d got %b want %b", i, obs_vec(), exp);
      end
      advance();
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    logic [8:0] exp;
    for (int i = 0; i < 400; i++) begin
      s.rst = ($urandom_range(0, 49) == 0);
      s.rs  = 5'($urandom_range(0, 3));
      s.rt  = 5'($urandom_range(0, 3));
      s.ut  = 1'($urandom_range(0, 1));
      s.br  = ($urandom_range(0, 3) == 0);
      s.exr = 1'($urandom_range(0, 1));
      s.ext = 5'($urandom_range(0, 3));
      s.mr  = ($urandom_range(0, 2) == 0);
      s.mw  = ($urandom_range(0, 3) == 0);
      s.rdy = ($urandom_range(0, 9) < 6);
      drive(s);
      exp = exp_q.pop_front();
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL random cycle %0d got %b want %b", i, obs_vec(), exp);
      end
      advance();
      checks++;
      if (state !== exp_state()) begin
        errors++;
        $display("FAIL random cycle %0d state got %0d want %0d", i, state, exp_state());
      end
    end
  endtask

  task automatic test_timeout();
    stim_t s;
    logic [8:0] exp;
    for (int i = 0; i < 11; i++) begin
      s = '{1'b0, 5'd5, 5'd6, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0};
      if (i == 0 || i == 9) s.rst = 1'b1;
      if (i == 10) s.mr = 1'b0;
      drive(s);
      exp = exp_q.pop_front();
      checks++;
      if (obs_vec() !== exp) begin
        errors++;
        $display("FAIL timeout step %0d got %b want %b", i, obs_vec(), exp);
      end
      advance();
      checks++;
      if (state !== exp_state()) begin
        errors++;
        $display("FAIL timeout step %0d state got %0d want %0d", i, state, exp_state());
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.ID_Rs = '0; bus.ID_Rt = '0; bus.ID_UsesRt = 1'b0; bus.ID_BranchTaken = 1'b0;
    bus.EX_MemRead = 1'b0; bus.EX_Rt = '0; bus.MEM_MemRead = 1'b0;
    bus.MEM_MemWrite = 1'b0; bus.dmem_ready = 1'b0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_coincidence();
    test_back_to_back();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Detects load-use hazards between the ID and EX stages.
- Handles branch/jump squash of IF/ID.
- Runs a handshake FSM for multi-cycle data-memory accesses in MEM.
- Drives hold/flush controls for PC, IF/ID, ID/EX and EX/MEM, plus a bubble control that zeroes RegWrite entering the MEM/WB register.

Parameters:
MEM_TIMEOUT, 64, max WAIT cycles on one data-memory access before entering ERROR (must be >=2; counter width = $clog2(MEM_TIMEOUT+1))

Ports:
clk  in  1  pipeline clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
ID_Rs  in  5  rs field of the instruction in ID
ID_Rt  in  5  rt field of the instruction in ID
ID_UsesRt  in  1  the ID instruction reads rt as a source
ID_BranchTaken  in  1  branch/jump resolved taken in ID this cycle
EX_MemRead  in  1  the EX instruction is a load
EX_Rt  in  5  destination register of the EX load
MEM_MemRead  in  1  the MEM instruction is a load
MEM_MemWrite  in  1  the MEM instruction is a store
dmem_ready  in  1  data memory completes the current access this cycle
dmem_req  out  1  data-memory access request, held until ready
PC_Stall  out  1  hold PC
IFID_Stall  out  1  hold IF/ID
IFID_Flush  out  1  clear IF/ID to a nop
IDEX_Stall  out  1  hold ID/EX
IDEX_Flush  out  1  clear ID/EX to a bubble
EXMEM_Stall  out  1  hold EX/MEM
MEMWB_Bubble  out  1  force MEM_RegWrite=0 into MEM/WB this cycle
mem_timeout  out  1  sticky error flag; set on entering ERROR

Behaviour:
Clocking:
- Single clock domain (clk).
- reset is synchronous and active-high; no asynchronous reset path.

State and outputs:
- FSM states: IDLE, WAIT, ERROR. Encoding lives in the package.
- Outputs are combinational from state and inputs.
- While reset=1, every output is forced to 0. On the next edge: state=IDLE, counter=0, mem_timeout=0.

Memory FSM:
- mem_acc = MEM_MemRead | MEM_MemWrite.
- IDLE:
  - dmem_req = mem_acc.
  - If mem_acc & dmem_ready: zero-wait access, no stall, stay in IDLE.
  - If mem_acc & ~dmem_ready: memstall=1 this cycle; go to WAIT with cnt=1.
- WAIT:
  - dmem_req=1.
  - If dmem_ready: memstall=0; go to IDLE; pipeline advances in this same cycle.
  - Else: memstall=1; cnt++.
  - If cnt==MEM_TIMEOUT and ~dmem_ready: go to ERROR.
- ERROR:
  - dmem_req=0, memstall=1, mem_timeout=1.
  - Held until reset.
- memstall=1 implies:
  - PC_Stall, IFID_Stall, IDEX_Stall, EXMEM_Stall all =1.
  - MEMWB_Bubble=1.
  - IFID_Flush=0 and IDEX_Flush=0.
- Total access latency = 1 + number of wait cycles. An N-cycle access inserts N-1 WB bubbles.

Load-use hazard:
- lu = EX_MemRead & (EX_Rt!=0) & ((EX_Rt==ID_Rs) | (ID_UsesRt & (EX_Rt==ID_Rt))).
- When lu & ~memstall: PC_Stall=1, IFID_Stall=1, IDEX_Flush=1.
- Exactly one bubble per hazard, since the load leaves EX on the next edge.

Branch squash:
- IFID_Flush = ID_BranchTaken & ~lu & ~memstall.

Priority:
- memstall > lu > branch.
- A taken branch that coincides with lu is suppressed. The held ID instruction re-resolves the branch next cycle.
- Register $0 never causes a hazard.

Optional Feature:
Macro: PIPE_HAZARD_PERF_EN
- Defined:
  - Adds output ports perf_memstall_cnt[31:0] (counts memstall cycles) and perf_lu_cnt[31:0] (counts load-use bubbles).
  - Both counters cleared by reset and wrap at 2^32.
  - Neither counter increments during reset.
- Undefined:
  - Ports and counters are absent.
  - Core behaviour is identical.

Decomposition:
- Package mips_pipe_pkg holds:
  - State enum HZ_IDLE/HZ_WAIT/HZ_ERROR.
  - REG_W=5.
  - ZERO_REG=5'd0.
- Sub-module load_use_detect: combinational lu equation. Keeps the FSM file focused on sequencing.

Test Plan:
1. Reset with mem_acc=1 and dmem_ready=0: all outputs 0 during reset; after reset deasserts, the FSM starts from IDLE.
2. Load-use: EX_MemRead=1, EX_Rt=8, ID_Rs=8: PC_Stall=IFID_Stall=IDEX_Flush=1 for exactly 1 cycle. The same case with EX_Rt=0 gives no stall. With ID_Rt=8 and ID_UsesRt=0 there is no stall.
3. Memory wait: MEM_MemRead=1, dmem_ready=0 for 3 cycles then 1:
   - All stalls and MEMWB_Bubble =1 for 3 cycles.
   - Released in the ready cycle.
   - dmem_req high for 4 cycles.
   - FSM back in IDLE.
4. Zero-wait store: MEM_MemWrite=1 with dmem_ready=1: dmem_req=1, no stall.
5. Coincidence: lu, ID_BranchTaken and memstall all active: only memstall controls asserted. Once memstall clears: lu stall, IFID_Flush=0. The following cycle the branch is flushed.
6. Timeout with MEM_TIMEOUT=4 and dmem_ready held at 0: ERROR reached after 4 WAIT cycles; mem_timeout=1 sticky; stalls held; a synchronous reset clears everything.
